// File: rtl/decode_stage.sv
// decode_stage: registered RV32I instruction-decode stage (ID/EX register).
//
// Decodes the opcode of a fetched instruction into the execute control
// bundle, extracts the register/funct3 fields and holds the result in an
// output register with valid/ready handshakes. A synchronous flush kills the
// stage contents, and an optional load-use detector inserts a single bubble
// when the instruction being offered reads the destination of a load that is
// leaving the stage this cycle.
//
// Parameters:
//   XLEN       PC width
//   HAZARD_EN  1 enables load-use bubble insertion, 0 ties the hazard term low
//   CNT_W      width of the saturating bubble counter
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    synchronous kill of the stage contents
//   in_valid / in_ready      fetch-side handshake
//   in_instr, in_pc          instruction word and its PC
//   out_valid / out_ready    execute-side handshake
//   out_pc                   registered PC
//   out_rd/rs1/rs2/funct3    registered instruction fields
//   reg_write, branch, op_b, store, mem_to_reg, imm_sel, op_a, next_pc, alu,
//   alu_sel                  registered control bundle
//   illegal                  registered "opcode not recognised" flag
//   stall_cnt                saturating count of inserted load-use bubbles
module decode_stage #(
  parameter int unsigned XLEN      = 32,
  parameter bit          HAZARD_EN = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic             reg_write,
  output logic             branch,
  output logic             op_b,
  output logic             store,
  output logic             mem_to_reg,
  output logic [1:0]       imm_sel,
  output logic [1:0]       op_a,
  output logic [1:0]       next_pc,
  output logic [2:0]       alu,
  output logic [3:0]       alu_sel,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned REG_W = 5;

  // Opcode classes
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_L   = 7'b0000011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_J   = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;

  // Control bundle carried through the output register
  typedef struct packed {
    logic       reg_write;
    logic       branch;
    logic       store;
    logic       mem_to_reg;
    logic [1:0] op_a;
    logic       op_b;
    logic [1:0] imm_sel;
    logic [1:0] next_pc;
    logic [2:0] alu;
    logic [3:0] alu_sel;
    logic       illegal;
  } ctrl_t;

  // Instruction fields of the offered instruction
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [REG_W-1:0] rd;
  logic [REG_W-1:0] rs1;
  logic [REG_W-1:0] rs2;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];

  // Immediate bits are consumed in execute, not here
  logic unused_imm_bits;
  assign unused_imm_bits = ^{in_instr[31], in_instr[29:25]};

  // Decoded bundle and source-usage flags
  ctrl_t dec;
  logic  uses_rs1;
  logic  uses_rs2;

  // Opcode decode
  always_comb begin
    dec      = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        dec.op_b      = 1'b1;
        dec.imm_sel   = 2'b11;
        dec.alu       = 3'b000;
        dec.alu_sel   = {in_instr[30], funct3};
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
      end
      OP_I: begin
        dec.reg_write = 1'b1;
        dec.op_b      = 1'b1;
        dec.imm_sel   = 2'b00;
        dec.alu       = 3'b001;
        // Only the shift-right funct3 uses bit 30 as an arithmetic flag
        dec.alu_sel   = {in_instr[30] & (funct3 == 3'b101), funct3};
        uses_rs1      = 1'b1;
      end
      OP_L: begin
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.imm_sel    = 2'b11;
        dec.alu        = 3'b010;
        dec.alu_sel    = 4'b1010;
        uses_rs1       = 1'b1;
      end
      OP_JR: begin
        dec.reg_write = 1'b1;
        dec.op_b      = 1'b1;
        dec.imm_sel   = 2'b11;
        dec.next_pc   = 2'b10;
        dec.alu       = 3'b011;
        dec.alu_sel   = 4'b1111;
        uses_rs1      = 1'b1;
      end
      OP_S: begin
        dec.store   = 1'b1;
        dec.op_b    = 1'b1;
        dec.imm_sel = 2'b01;
        dec.alu     = 3'b100;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
      end
      OP_B: begin
        dec.branch  = 1'b1;
        dec.imm_sel = 2'b11;
        dec.next_pc = 2'b11;
        dec.alu     = 3'b000;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
      end
      OP_AUI: begin
        dec.reg_write = 1'b1;
        dec.op_a      = 2'b10;
        dec.op_b      = 1'b1;
        dec.imm_sel   = 2'b10;
        dec.alu       = 3'b101;
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.op_a      = 2'b11;
        dec.op_b      = 1'b1;
        dec.imm_sel   = 2'b10;
        dec.alu       = 3'b110;
      end
      OP_J: begin
        dec.reg_write = 1'b1;
        dec.op_a      = 2'b10;
        dec.imm_sel   = 2'b11;
        dec.next_pc   = 2'b01;
        dec.alu       = 3'b111;
        dec.alu_sel   = 4'b1111;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Output register state
  logic             valid_q;
  logic [XLEN-1:0]  pc_q;
  logic [REG_W-1:0] rd_q;
  logic [REG_W-1:0] rs1_q;
  logic [REG_W-1:0] rs2_q;
  logic [2:0]       funct3_q;
  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] stall_q;

  // Load-use: a load leaving now cannot forward to an instruction entering now
  logic rs_match;
  logic load_use;
  logic hazard;
  logic accept;

  assign rs_match = (uses_rs1 & (rs1 == rd_q)) | (uses_rs2 & (rs2 == rd_q));
  assign load_use = valid_q & out_ready & ctrl_q.mem_to_reg & (rd_q != REG_W'(0))
                  & in_valid & rs_match;
  assign hazard   = HAZARD_EN & load_use;
  assign in_ready = flush | ((~valid_q | out_ready) & ~hazard);
  assign accept   = in_valid & in_ready;

  // ID/EX register; flush beats hazard beats load beats drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      funct3_q <= '0;
      ctrl_q   <= '0;
      stall_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (hazard) begin
      valid_q <= 1'b0;
      if (stall_q != {CNT_W{1'b1}}) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end else if (accept) begin
      valid_q  <= 1'b1;
      pc_q     <= in_pc;
      rd_q     <= rd;
      rs1_q    <= rs1;
      rs2_q    <= rs2;
      funct3_q <= funct3;
      ctrl_q   <= dec;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Output mapping
  assign out_valid  = valid_q;
  assign out_pc     = pc_q;
  assign out_rd     = rd_q;
  assign out_rs1    = rs1_q;
  assign out_rs2    = rs2_q;
  assign out_funct3 = funct3_q;
  assign reg_write  = ctrl_q.reg_write;
  assign branch     = ctrl_q.branch;
  assign op_b       = ctrl_q.op_b;
  assign store      = ctrl_q.store;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign imm_sel    = ctrl_q.imm_sel;
  assign op_a       = ctrl_q.op_a;
  assign next_pc    = ctrl_q.next_pc;
  assign alu        = ctrl_q.alu;
  assign alu_sel    = ctrl_q.alu_sel;
  assign illegal    = ctrl_q.illegal;
  assign stall_cnt  = stall_q;

endmodule
